seq_mag_comp: RTL and testbench

Multi-cycle magnitude comparator for wide operands. It compares two WIDTH-bit operands one CHUNK-bit slice per cycle, starting at the most-significant slice. It returns one-hot greater/equal/less flags through a valid/ready handshake. It replaces the flat 16-bit combinational comparator in datapaths where operand width, signedness and area-vs-latency tradeoff must be configurable.

---
 rtl/seq_mag_comp.sv | 202 ++++++++++++++++++++
 tb/tb_seq_mag_comp.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mag_comp.sv
//------------------------------------------------------------------------------
// seq_mag_comp
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are compared one
// CHUNK-bit slice per cycle, most-significant slice first. The result is
// returned as one-hot gt/eq/lt flags through a valid/ready handshake.
//
// Signed compares are reduced to unsigned ones by inverting the operand sign
// bits at capture time. After that, every slice compare is a plain unsigned
// compare.
//
// Build option:
//   SEQ_MAG_COMP_EARLY_EXIT_EN
//     Defined   : RUN stops on the first unequal slice. Latency is 1..NCH.
//     Undefined : RUN always walks all NCH slices. The first unequal slice
//                 latches a sticky decision, and later slices cannot change
//                 it. Latency is fixed at NCH. The flags are identical.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_mag_comp #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Flip the sign bit when signed: two's-complement order then matches
  // unsigned order on the biased value.
  function automatic logic [WIDTH-1:0] bias_msb(input logic [WIDTH-1:0] v,
                                                input logic             s);
    logic [WIDTH-1:0] r;
    r            = v;
    r[WIDTH-1]   = v[WIDTH-1] ^ s;
    return r;
  endfunction

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_out_valid;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

`ifndef SEQ_MAG_COMP_EARLY_EXIT_EN
  logic             r_dec_valid;   // an unequal slice has already been seen
  logic             r_dec_gt;      // direction of that first difference
`endif

  // Slice views of the registered operands, indexed by slice number.
  logic [CHUNK-1:0] w_slices_a [NCH];
  logic [CHUNK-1:0] w_slices_b [NCH];

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_slice
      assign w_slices_a[g] = r_a[g*CHUNK +: CHUNK];
      assign w_slices_b[g] = r_b[g*CHUNK +: CHUNK];
    end
  endgenerate

  logic [CHUNK-1:0] w_cur_a;
  logic [CHUNK-1:0] w_cur_b;
  logic             w_sl_gt;
  logic             w_sl_lt;
  logic             w_fin_gt;
  logic             w_fin_lt;

  // Compare the current slice pair and merge it with any earlier decision.
  always_comb begin
    w_cur_a  = w_slices_a[r_idx];
    w_cur_b  = w_slices_b[r_idx];
    w_sl_gt  = (w_cur_a > w_cur_b);
    w_sl_lt  = (w_cur_a < w_cur_b);
`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
    w_fin_gt = w_sl_gt;
    w_fin_lt = w_sl_lt;
`else
    if (r_dec_valid) begin
      w_fin_gt = r_dec_gt;
      w_fin_lt = ~r_dec_gt;
    end else begin
      w_fin_gt = w_sl_gt;
      w_fin_lt = w_sl_lt;
    end
`endif
  end

  // Control FSM: capture operands, walk the slices, hold the result until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= IW'(0);
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_gt        <= 1'b0;
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
`ifndef SEQ_MAG_COMP_EARLY_EXIT_EN
      r_dec_valid <= 1'b0;
      r_dec_gt    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= bias_msb(op_a, signed_mode);
            r_b     <= bias_msb(op_b, signed_mode);
            r_idx   <= IW'(NCH - 1);
            r_state <= S_RUN;
`ifndef SEQ_MAG_COMP_EARLY_EXIT_EN
            r_dec_valid <= 1'b0;
            r_dec_gt    <= 1'b0;
`endif
          end
        end

        S_RUN: begin
`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
          if (w_sl_gt) begin
            r_gt        <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_sl_lt) begin
            r_lt        <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_idx == IW'(0)) begin
            r_eq        <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
`else
          if (r_idx == IW'(0)) begin
            r_gt        <= w_fin_gt;
            r_lt        <= w_fin_lt;
            r_eq        <= ~(w_fin_gt | w_fin_lt);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            if (!r_dec_valid && (w_sl_gt || w_sl_lt)) begin
              r_dec_valid <= 1'b1;
              r_dec_gt    <= w_sl_gt;
            end
            r_idx <= r_idx - IW'(1);
          end
`endif
        end

        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_gt        <= 1'b0;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_gt        <= 1'b0;
          r_eq        <= 1'b0;
          r_lt        <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign gt        = r_gt;
  assign eq        = r_eq;
  assign lt        = r_lt;

endmodule

// File: tb/tb_seq_mag_comp.sv
//------------------------------------------------------------------------------
// tb_seq_mag_comp: directed, self-checking bench for seq_mag_comp
// (WIDTH=32, CHUNK=8). Expected latencies track SEQ_MAG_COMP_EARLY_EXIT_EN.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_seq_mag_comp;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
  localparam int LAT_MSB = 1;
`else
  localparam int LAT_MSB = 4;
`endif
  localparam int LAT_FULL = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             eq;
  logic             lt;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mag_comp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .signed_mode(signed_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .gt         (gt),
    .eq         (eq),
    .lt         (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for one accept edge, then count edges until out_valid.
  task automatic do_compare(input logic [31:0] a, input logic [31:0] b, input logic s,
                            output int lat, output logic [2:0] flags);
    in_valid    = 1'b1;
    op_a        = a;
    op_b        = b;
    signed_mode = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = -1;
    flags    = 3'b000;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        lat   = c;
        flags = {gt, eq, lt};
        break;
      end
    end
  endtask

  // Hold out_ready high for one edge to take the result.
  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, gt, eq, lt} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", {in_ready, out_valid, gt, eq, lt}, 5'b10000);
    end
  endtask

  task automatic test_equal();
    int lat; logic [2:0] f;
    do_compare(32'h12345678, 32'h12345678, 1'b0, lat, f);
    n_checks++;
    if (lat !== LAT_FULL) begin
      n_fail++; $display("FAIL equal_latency: got %0d expected %0d", lat, LAT_FULL);
    end
    n_checks++;
    if (f !== 3'b010) begin
      n_fail++; $display("FAIL equal_flags: got %b expected %b", f, 3'b010);
    end
    release_result();
    n_checks++;
    if ({in_ready, out_valid, gt, eq, lt} !== 5'b10000) begin
      n_fail++;
      $display("FAIL equal_after_handshake: got %b expected %b", {in_ready, out_valid, gt, eq, lt}, 5'b10000);
    end
  endtask

  task automatic test_msb_unsigned();
    int lat; logic [2:0] f;
    do_compare(32'h80000000, 32'h7FFFFFFF, 1'b0, lat, f);
    n_checks++;
    if (lat !== LAT_MSB) begin
      n_fail++; $display("FAIL msb_unsigned_latency: got %0d expected %0d", lat, LAT_MSB);
    end
    n_checks++;
    if (f !== 3'b100) begin
      n_fail++; $display("FAIL msb_unsigned_flags: got %b expected %b", f, 3'b100);
    end
    release_result();
  endtask

  task automatic test_signed();
    int lat; logic [2:0] f;
    do_compare(32'h80000000, 32'h7FFFFFFF, 1'b1, lat, f);
    n_checks++;
    if (lat !== LAT_MSB) begin
      n_fail++; $display("FAIL signed_latency: got %0d expected %0d", lat, LAT_MSB);
    end
    n_checks++;
    if (f !== 3'b001) begin
      n_fail++; $display("FAIL signed_flags: got %b expected %b", f, 3'b001);
    end
    release_result();
  endtask

  task automatic test_lsb();
    int lat; logic [2:0] f;
    do_compare(32'h123456FF, 32'h12345600, 1'b0, lat, f);
    n_checks++;
    if (lat !== LAT_FULL || f !== 3'b100) begin
      n_fail++; $display("FAIL lsb_gt: got lat %0d flags %b expected lat %0d flags %b", lat, f, LAT_FULL, 3'b100);
    end
    release_result();
    do_compare(32'h12345600, 32'h123456FF, 1'b0, lat, f);
    n_checks++;
    if (lat !== LAT_FULL || f !== 3'b001) begin
      n_fail++; $display("FAIL lsb_lt: got lat %0d flags %b expected lat %0d flags %b", lat, f, LAT_FULL, 3'b001);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat; logic [2:0] f;
    do_compare(32'h00000005, 32'h00000003, 1'b0, lat, f);
    n_checks++;
    if (lat !== LAT_FULL || f !== 3'b100) begin
      n_fail++; $display("FAIL bp_result: got lat %0d flags %b expected lat %0d flags %b", lat, f, LAT_FULL, 3'b100);
    end
    // A new request while the result is pending must be ignored.
    in_valid = 1'b1;
    op_a     = 32'h00000000;
    op_b     = 32'hFFFFFFFF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({in_ready, out_valid, gt, eq, lt} !== 5'b01100) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got %b expected %b", c, {in_ready, out_valid, gt, eq, lt}, 5'b01100);
      end
    end
    in_valid = 1'b0;
    release_result();
    n_checks++;
    if ({in_ready, out_valid, gt, eq, lt} !== 5'b10000) begin
      n_fail++;
      $display("FAIL bp_release: got %b expected %b", {in_ready, out_valid, gt, eq, lt}, 5'b10000);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [2:0] f; int seen;
    in_valid    = 1'b1;
    op_a        = 32'hCAFEF00D;
    op_b        = 32'hCAFEF00D;
    signed_mode = 1'b0;
    @(posedge clk); #1;            // accept edge E0
    in_valid = 1'b0;
    @(posedge clk); #1;            // E1: now in the 2nd RUN cycle
    rst = 1'b1;
    @(posedge clk); #1;            // E2: reset sampled
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, gt, eq, lt} !== 5'b10000) begin
      n_fail++;
      $display("FAIL abort_state: got %b expected %b", {in_ready, out_valid, gt, eq, lt}, 5'b10000);
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL abort_no_result: got %0d valid cycles expected %0d", seen, 0);
    end
    do_compare(32'h00000001, 32'h00000002, 1'b0, lat, f);
    n_checks++;
    if (lat !== LAT_FULL || f !== 3'b001) begin
      n_fail++; $display("FAIL after_abort: got lat %0d flags %b expected lat %0d flags %b", lat, f, LAT_FULL, 3'b001);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat; logic [2:0] f;
    out_ready = 1'b1;
    do_compare(32'hFFFFFFFF, 32'h00000000, 1'b1, lat, f);   // -1 < 0
    n_checks++;
    if (lat !== LAT_MSB || f !== 3'b001) begin
      n_fail++; $display("FAIL b2b_first: got lat %0d flags %b expected lat %0d flags %b", lat, f, LAT_MSB, 3'b001);
    end
    @(posedge clk); #1;            // handshake edge with out_ready held high
    n_checks++;
    if ({in_ready, out_valid, gt, eq, lt} !== 5'b10000) begin
      n_fail++;
      $display("FAIL b2b_idle: got %b expected %b", {in_ready, out_valid, gt, eq, lt}, 5'b10000);
    end
    do_compare(32'h7FFFFFFF, 32'h80000000, 1'b1, lat, f);   // max > min
    n_checks++;
    if (lat !== LAT_MSB || f !== 3'b100) begin
      n_fail++; $display("FAIL b2b_second: got lat %0d flags %b expected lat %0d flags %b", lat, f, LAT_MSB, 3'b100);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    op_a        = '0;
    op_b        = '0;
    signed_mode = 1'b0;
    out_ready   = 1'b0;
    test_reset();
    test_equal();
    test_msb_unsigned();
    test_signed();
    test_lsb();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
